// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// rv32i_pkg : shared RV32I constants (funct3 widths, LSU fault causes, states)
// Revision  : 1.0
// ============================================================================
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_ILLEGAL   = 2'b00;
    localparam logic [1:0] CAUSE_MIS_LOAD  = 2'b01;
    localparam logic [1:0] CAUSE_MIS_STORE = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } lsu_state_t;

    // Unsigned widths exist only for loads.
    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// lsu_align : byte-lane enables, store replication and load extension
// Revision  : 1.0
// ============================================================================
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign sel_half = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data = 32'd0;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_HU:   load_data = {16'd0, sel_half};
            default: load_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// lsu : RV32I load/store unit - req/ack bus FSM with fault and timeout reporting
// Revision  : 1.0
// ============================================================================
module lsu
    import rv32i_pkg::*;
#(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);

    lsu_state_t state, state_next;

    logic             req_store;
    logic [2:0]       req_funct3;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [31:0]      rdata_q;
    logic [1:0]       cause_q;
    logic [CNT_W-1:0] wait_cnt;

    logic             start_fault;
    logic [1:0]       start_cause;
    logic             timeout_hit;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata;
    logic [31:0]      al_load;

    lsu_align u_align (
        .funct3     (req_funct3),
        .addr_lo    (req_addr[1:0]),
        .store_data (req_wdata),
        .rdata      (rdata_q),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    // Request is screened from the live decoder inputs so faults skip the bus.
    always_comb begin
        start_fault = 1'b1;
        start_cause = CAUSE_ILLEGAL;
        if (!f3_legal(is_store, funct3))
            start_cause = CAUSE_ILLEGAL;
        else if (f3_misaligned(funct3, addr[1:0]))
            start_cause = is_store ? CAUSE_MIS_STORE : CAUSE_MIS_LOAD;
        else
            start_fault = 1'b0;
    end

    // Counter holds cycles already spent in REQ, so the last allowed cycle is BUS_TIMEOUT-1.
    assign timeout_hit = (wait_cnt == CNT_W'(BUS_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        fault       = 1'b0;
        fault_cause = 2'b00;
        load_data   = 32'd0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;
        mem_be      = 4'b0000;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    busy       = 1'b1;
                    state_next = start_fault ? ST_FAULT : ST_REQ;
                end
            end
            ST_REQ: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = req_store;
                mem_addr  = {req_addr[31:2], 2'b00};
                mem_be    = al_be;
                mem_wdata = req_store ? al_wdata : 32'd0;
                if (mem_ack)          state_next = ST_DONE;
                else if (timeout_hit) state_next = ST_FAULT;
            end
            ST_DONE: begin
                done       = 1'b1;
                load_data  = req_store ? 32'd0 : al_load;
                state_next = ST_IDLE;
            end
            ST_FAULT: begin
                done        = 1'b1;
                fault       = 1'b1;
                fault_cause = cause_q;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_store  <= 1'b0;
            req_funct3 <= 3'b000;
            req_addr   <= 32'd0;
            req_wdata  <= 32'd0;
            rdata_q    <= 32'd0;
            cause_q    <= 2'b00;
            wait_cnt   <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                req_store  <= is_store;
                req_funct3 <= funct3;
                req_addr   <= addr;
                req_wdata  <= store_data;
                cause_q    <= start_cause;
            end
            if (state == ST_REQ) begin
                if (mem_ack) begin
                    rdata_q <= mem_rdata;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (timeout_hit) cause_q <= CAUSE_TIMEOUT;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// tb_lsu : directed self-checking bench for the load/store unit
// Revision  : 1.0
// ============================================================================
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        busy, done, fault, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [1:0]  fault_cause;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    lsu #(.BUS_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .load_data(load_data), .fault(fault),
        .fault_cause(fault_cause), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if ({busy, done, fault, fault_cause} !== 5'd0) begin errors++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, fault, fault_cause}); end
        checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL reset_load_data got %h want 0", load_data); end
        checks++; if ({mem_req, mem_we, mem_be} !== 6'd0) begin errors++; $display("FAIL reset_bus_ctrl got %b want 0", {mem_req, mem_we, mem_be}); end
        checks++; if ({mem_addr, mem_wdata} !== 64'd0) begin errors++; $display("FAIL reset_bus_data got %h want 0", {mem_addr, mem_wdata}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_sw_nowait();
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy_c0 got %b want 1", busy); end
        tick();
        start = 1'b0;
        checks++; if ({mem_req, mem_we, busy} !== 3'b111) begin errors++; $display("FAIL sw_req_c1 got %b want 111", {mem_req, mem_we, busy}); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL sw_addr got %h want 00000100", mem_addr); end
        checks++; if (mem_be !== 4'b1111) begin errors++; $display("FAIL sw_be got %b want 1111", mem_be); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h want deadbeef", mem_wdata); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++; if ({done, fault, busy, mem_req} !== 4'b1000) begin errors++; $display("FAIL sw_done_c2 got %b want 1000", {done, fault, busy, mem_req}); end
        checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL sw_load_data got %h want 0", load_data); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL sw_done_pulse got %b want 0", done); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3_t [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
        logic [31:0] a_t  [6] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200, 32'h204};
        logic [31:0] rd_t [6] = '{32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h89ABCDEF};
        logic [31:0] ex_t [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00000034, 32'h89ABCDEF};
        logic [3:0]  be_t [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0001, 4'b1111};
        logic [31:0] ma_t [6] = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h200, 32'h204};
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, f3_t[i], a_t[i], 32'hFFFFFFFF);
            tick();
            start = 1'b0;
            checks++; if ({mem_req, mem_we, mem_be} !== {2'b10, be_t[i]}) begin errors++; $display("FAIL load%0d_req got %b want %b", i, {mem_req, mem_we, mem_be}, {2'b10, be_t[i]}); end
            checks++; if (mem_addr !== ma_t[i]) begin errors++; $display("FAIL load%0d_addr got %h want %h", i, mem_addr, ma_t[i]); end
            mem_ack = 1'b1; mem_rdata = rd_t[i];
            tick();
            mem_ack = 1'b0; mem_rdata = 32'h0;
            checks++; if ({done, fault} !== 2'b10) begin errors++; $display("FAIL load%0d_done got %b want 10", i, {done, fault}); end
            checks++; if (load_data !== ex_t[i]) begin errors++; $display("FAIL load%0d_data got %h want %h", i, load_data, ex_t[i]); end
            tick();
        end
    endtask

    task automatic test_sh_wait();
        issue(1'b1, 3'b001, 32'h102, 32'h0000ABCD);
        tick();
        // start stays high through REQ and must not recapture
        addr = 32'h500; store_data = 32'h11111111;
        for (int c = 0; c < 3; c++) begin
            checks++; if ({mem_req, mem_we, busy, done, mem_be} !== 8'b1110_1100) begin errors++; $display("FAIL sh_wait%0d_ctrl got %b want 11101100", c, {mem_req, mem_we, busy, done, mem_be}); end
            checks++; if ({mem_addr, mem_wdata} !== {32'h100, 32'hABCDABCD}) begin errors++; $display("FAIL sh_wait%0d_bus got %h want 00000100abcdabcd", c, {mem_addr, mem_wdata}); end
            tick();
        end
        start = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sh_req_at_ack got %b want 1", mem_req); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++; if ({done, fault, mem_req} !== 3'b100) begin errors++; $display("FAIL sh_done got %b want 100", {done, fault, mem_req}); end
        tick();
        // SB lane replication
        issue(1'b1, 3'b000, 32'h101, 32'h12345677);
        tick();
        start = 1'b0;
        checks++; if ({mem_be, mem_wdata} !== {4'b0010, 32'h77777777}) begin errors++; $display("FAIL sb_lanes got %h want 277777777", {mem_be, mem_wdata}); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_faults();
        logic        st_t [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3_t [7] = '{3'b010, 3'b001, 3'b100, 3'b011, 3'b111, 3'b101, 3'b010};
        logic [31:0] a_t  [7] = '{32'h101, 32'h3, 32'h10, 32'h0, 32'h0, 32'h201, 32'h102};
        logic [1:0]  cz_t [7] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
        for (int i = 0; i < 7; i++) begin
            issue(st_t[i], f3_t[i], a_t[i], 32'hA5A5A5A5);
            #1;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fault%0d_busy_c0 got %b want 1", i, busy); end
            tick();
            start = 1'b0;
            checks++; if ({done, fault, mem_req, busy} !== 4'b1100) begin errors++; $display("FAIL fault%0d_flags got %b want 1100", i, {done, fault, mem_req, busy}); end
            checks++; if (fault_cause !== cz_t[i]) begin errors++; $display("FAIL fault%0d_cause got %b want %b", i, fault_cause, cz_t[i]); end
            checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL fault%0d_data got %h want 0", i, load_data); end
            tick();
            checks++; if ({done, fault, mem_req} !== 3'b000) begin errors++; $display("FAIL fault%0d_idle got %b want 000", i, {done, fault, mem_req}); end
        end
    endtask

    task automatic test_timeout();
        int n;
        issue(1'b0, 3'b010, 32'h80, 32'h0);
        tick();
        start = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick();
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL timeout_req_cycles got %0d want 16", n); end
        checks++; if ({done, fault, fault_cause, busy} !== 5'b11110) begin errors++; $display("FAIL timeout_fault got %b want 11110", {done, fault, fault_cause, busy}); end
        checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL timeout_data got %h want 0", load_data); end
        tick();
        // ack on the final permitted cycle still completes normally
        issue(1'b0, 3'b010, 32'h84, 32'h0);
        tick();
        start = 1'b0;
        for (int c = 0; c < 15; c++) tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL timeout_edge_req got %b want 1", mem_req); end
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        checks++; if ({done, fault} !== 2'b10) begin errors++; $display("FAIL timeout_edge_done got %b want 10", {done, fault}); end
        checks++; if (load_data !== 32'hCAFEF00D) begin errors++; $display("FAIL timeout_edge_data got %h want cafef00d", load_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 3'b010, 32'h60, 32'h0);
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({mem_req, busy, done} !== 3'b000) begin errors++; $display("FAIL rst_mid_idle got %b want 000", {mem_req, busy, done}); end
        mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
        tick();
        mem_ack = 1'b0;
        checks++; if ({mem_req, done, fault, load_data} !== 35'd0) begin errors++; $display("FAIL rst_late_ack got %h want 0", {mem_req, done, fault, load_data}); end
        issue(1'b0, 3'b010, 32'h40, 32'h0);
        tick();
        start = 1'b0;
        checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL rst_new_req got %h want 100000040", {mem_req, mem_addr}); end
        mem_ack = 1'b1; mem_rdata = 32'h11223344;
        tick();
        mem_ack = 1'b0;
        checks++; if ({done, fault, load_data} !== {2'b10, 32'h11223344}) begin errors++; $display("FAIL rst_new_done got %h want 211223344", {done, fault, load_data}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_sw_nowait();
        test_loads();
        test_sh_wait();
        test_faults();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
